// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: round-robin owner of the shared tri-state bus; sequences
// turnaround, multi-beat drive and completion for one sender/receiver pair.
module bus_xfer_ctrl #(
   parameter int N_AGENT  = 4,
   parameter int IDX_W    = 2,
   parameter int LEN_W    = 4,
   parameter int TURN_CYC = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_AGENT-1:0]       req,
   input  logic [N_AGENT*IDX_W-1:0] dst,
   input  logic [N_AGENT*LEN_W-1:0] len,
   output logic [N_AGENT-1:0]       snd_en,
   output logic [N_AGENT-1:0]       rcv_en,
   output logic [N_AGENT-1:0]       grant,
   output logic                     beat,
   output logic [N_AGENT-1:0]       done,
   output logic [N_AGENT-1:0]       err,
   output logic                     busy
);
   typedef enum logic [1:0] {IDLE, TURN, DRIVE, DONE} state_t;
   state_t state_q, state_d;
   logic [IDX_W-1:0] src_q, src_d, dst_q, dst_d, rr_q, rr_d, pick, pick_dst;
   logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
   logic [2:0] tc_q, tc_d;
   logic [N_AGENT-1:0] snd_en_q, snd_en_d, rcv_en_q, rcv_en_d, grant_q, grant_d;
   logic [N_AGENT-1:0] done_q, done_d, err_q, err_d;
   logic beat_q, beat_d, busy_q, busy_d;
   // Scan downward so the closest requester after rr wins.
   always_comb begin
      pick = '0;
      for (int i = N_AGENT; i >= 1; i--)
         if (req[(int'(rr_q) + i) % N_AGENT]) pick = IDX_W'((int'(rr_q) + i) % N_AGENT);
      pick_dst = dst[int'(pick)*IDX_W +: IDX_W];
   end
   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      len_d    = len_q;
      rr_d     = rr_q;
      cnt_d    = cnt_q;
      tc_d     = tc_q;
      grant_d  = grant_q;
      snd_en_d = '0;
      rcv_en_d = '0;
      beat_d   = 1'b0;
      done_d   = '0;
      err_d    = '0;
      case (state_q)
         IDLE: if (|req) begin
            src_d = pick;
            dst_d = pick_dst;
            len_d = len[int'(pick)*LEN_W +: LEN_W];
            rr_d  = pick;
            if (pick_dst == pick || int'(pick_dst) >= N_AGENT) err_d = N_AGENT'(1) << pick;
            else begin
               grant_d = N_AGENT'(1) << pick;
               tc_d    = '0;
               state_d = TURN;
            end
         end
         TURN: if (int'(tc_q) == TURN_CYC - 1) begin
            state_d  = DRIVE;
            cnt_d    = '0;
            snd_en_d = N_AGENT'(1) << src_q;
            rcv_en_d = N_AGENT'(1) << dst_q;
            beat_d   = 1'b1;
         end else tc_d = tc_q + 3'd1;
         DRIVE: if (cnt_q == len_q) begin
            state_d = DONE;
            done_d  = N_AGENT'(1) << src_q;
         end else begin
            cnt_d    = cnt_q + 1'b1;
            snd_en_d = N_AGENT'(1) << src_q;
            rcv_en_d = N_AGENT'(1) << dst_q;
            beat_d   = 1'b1;
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         len_q    <= '0;
         rr_q     <= IDX_W'(N_AGENT - 1);
         cnt_q    <= '0;
         tc_q     <= '0;
         grant_q  <= '0;
         snd_en_q <= '0;
         rcv_en_q <= '0;
         beat_q   <= 1'b0;
         done_q   <= '0;
         err_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         len_q    <= len_d;
         rr_q     <= rr_d;
         cnt_q    <= cnt_d;
         tc_q     <= tc_d;
         grant_q  <= grant_d;
         snd_en_q <= snd_en_d;
         rcv_en_q <= rcv_en_d;
         beat_q   <= beat_d;
         done_q   <= done_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
      end
   end
   assign snd_en = snd_en_q;
   assign rcv_en = rcv_en_q;
   assign grant  = grant_q;
   assign beat   = beat_q;
   assign done   = done_q;
   assign err    = err_q;
   assign busy   = busy_q;
endmodule
